// File: rtl/ipg_wreq_rx.sv
// rtl/ipg_wreq_rx.sv - IPG write-request frame receiver
// Parses FIRST / address WRITEs / data WRITEs / LAST into a request descriptor, chunk stream and error pulses.
module ipg_wreq_rx #(
  parameter int DATA_WIDTH     = 64,
  parameter int HDR_WIDTH      = 16,
  parameter int ADDR_BLKS      = 2,
  parameter int MAX_CHUNKS     = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DATA_WIDTH-1:0]                 rx_ipg_data,
  input  logic [5:0]                            rx_len,
  input  logic                                  rx_valid,
  output logic [DATA_WIDTH-9:0]                 hdr_out,
  output logic [(DATA_WIDTH-8)*ADDR_BLKS-1:0]   addr_out,
  output logic                                  req_valid,
  output logic [DATA_WIDTH-1:0]                 chunk_data,
  output logic                                  chunk_valid,
  output logic                                  chunk_last,
  output logic                                  err,
  output logic [2:0]                            err_code
);

  localparam int FW = DATA_WIDTH - 8;
  localparam int BW = $clog2(MAX_CHUNKS + 1);
  localparam int CW = (BW > HDR_WIDTH + 1) ? BW : HDR_WIDTH + 1;
  localparam int AW = (ADDR_BLKS > 1) ? $clog2(ADDR_BLKS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [7:0] T_FIRST = 8'h0c;
  localparam logic [7:0] T_WRITE = 8'h1c;
  localparam logic [7:0] T_LAST  = 8'h2c;

  localparam logic [2:0] E_ABORT    = 3'd1;
  localparam logic [2:0] E_SHORT    = 3'd2;
  localparam logic [2:0] E_BADTYPE  = 3'd3;
  localparam logic [2:0] E_OVERFLOW = 3'd4;
  localparam logic [2:0] E_LEN      = 3'd5;
  localparam logic [2:0] E_TIMEOUT  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        idle_cnt, idle_n, idle_inc;
  logic [AW-1:0]        addr_cnt;
  logic [BW-1:0]        beat_cnt, beat_next;
  logic [HDR_WIDTH-1:0] len_q;
  logic [FW-1:0]        addr_q [ADDR_BLKS];

  logic [7:0]           typ;
  logic [FW-1:0]        field;
  logic [HDR_WIDTH:0]   exp_ceil, exp_beats;
  logic                 len_mismatch;

  logic                 load_hdr, addr_we;
  logic                 req_n, chunk_n, last_n, err_n;
  logic [2:0]           code_n;

  logic                 unused_rx_len;
  assign unused_rx_len = ^rx_len;

  assign typ       = rx_ipg_data[7:0];
  assign field     = rx_ipg_data[DATA_WIDTH-1:8];
  assign beat_next = beat_cnt + BW'(1);
  assign idle_inc  = idle_cnt + TW'(1);

  // Expected beat count is ceil(len/7), never below one; kept one bit wider so it cannot wrap.
  assign exp_ceil     = ({1'b0, len_q} + (HDR_WIDTH+1)'(6)) / (HDR_WIDTH+1)'(7);
  assign exp_beats    = (exp_ceil == '0) ? (HDR_WIDTH+1)'(1) : exp_ceil;
  assign len_mismatch = CW'(beat_next) != CW'(exp_beats);

  for (genvar k = 0; k < ADDR_BLKS; k++) begin : g_addr
    assign addr_out[(ADDR_BLKS-k)*FW-1 -: FW] = addr_q[k];
  end

  always_comb begin
    state_n  = state;
    idle_n   = idle_cnt;
    load_hdr = 1'b0;
    addr_we  = 1'b0;
    req_n    = 1'b0;
    chunk_n  = 1'b0;
    last_n   = 1'b0;
    err_n    = 1'b0;
    code_n   = 3'd0;

    if (!rx_valid) begin
      if ((state == S_ADDR || state == S_DATA) && TIMEOUT_CYCLES != 0) begin
        if (idle_inc == TW'(TIMEOUT_CYCLES)) begin
          err_n   = 1'b1;
          code_n  = E_TIMEOUT;
          idle_n  = '0;
          state_n = S_IDLE;
        end else begin
          idle_n = idle_inc;
        end
      end
    end else begin
      idle_n = '0;
      unique case (state)
        S_IDLE: begin
          if (typ == T_FIRST) begin
            load_hdr = 1'b1;
            state_n  = S_ADDR;
          end
        end
        S_ADDR: begin
          if (typ == T_WRITE) begin
            addr_we = 1'b1;
            if (addr_cnt == AW'(ADDR_BLKS - 1)) begin
              req_n   = 1'b1;
              state_n = S_DATA;
            end
          end else if (typ == T_FIRST) begin
            err_n    = 1'b1;
            code_n   = E_ABORT;
            load_hdr = 1'b1;
          end else if (typ == T_LAST) begin
            err_n   = 1'b1;
            code_n  = E_SHORT;
            state_n = S_IDLE;
          end else begin
            err_n   = 1'b1;
            code_n  = E_BADTYPE;
            state_n = S_DRAIN;
          end
        end
        S_DATA: begin
          if (typ == T_WRITE) begin
            chunk_n = 1'b1;
            if (beat_next == BW'(MAX_CHUNKS)) begin
              err_n   = 1'b1;
              code_n  = E_OVERFLOW;
              state_n = S_DRAIN;
            end
          end else if (typ == T_LAST) begin
            chunk_n = 1'b1;
            last_n  = 1'b1;
            state_n = S_IDLE;
            if (len_mismatch) begin
              err_n  = 1'b1;
              code_n = E_LEN;
            end
          end else if (typ == T_FIRST) begin
            err_n    = 1'b1;
            code_n   = E_ABORT;
            load_hdr = 1'b1;
            state_n  = S_ADDR;
          end else begin
            err_n   = 1'b1;
            code_n  = E_BADTYPE;
            state_n = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // A fresh header recovers directly; the error was already reported on entry.
          if (typ == T_LAST) begin
            state_n = S_IDLE;
          end else if (typ == T_FIRST) begin
            load_hdr = 1'b1;
            state_n  = S_ADDR;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idle_cnt    <= '0;
      addr_cnt    <= '0;
      beat_cnt    <= '0;
      len_q       <= '0;
      hdr_out     <= '0;
      for (int k = 0; k < ADDR_BLKS; k++) addr_q[k] <= '0;
      req_valid   <= 1'b0;
      chunk_valid <= 1'b0;
      chunk_last  <= 1'b0;
      chunk_data  <= '0;
      err         <= 1'b0;
      err_code    <= 3'd0;
    end else begin
      state       <= state_n;
      idle_cnt    <= idle_n;
      req_valid   <= req_n;
      chunk_valid <= chunk_n;
      chunk_last  <= last_n;
      err         <= err_n;
      if (err_n) err_code <= code_n;
      if (chunk_n) begin
        chunk_data <= rx_ipg_data;
        beat_cnt   <= beat_next;
      end
      if (load_hdr) begin
        hdr_out  <= field;
        len_q    <= field[HDR_WIDTH-1:0];
        addr_cnt <= '0;
        beat_cnt <= '0;
      end
      if (addr_we) begin
        addr_q[addr_cnt] <= field;
        addr_cnt         <= addr_cnt + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ipg_wreq_rx.sv
// tb/tb_ipg_wreq_rx.sv - self-checking bench for ipg_wreq_rx
// Frames are built as block lists; expected outputs per cycle are derived from frame-level rules.
module tb_ipg_wreq_rx;

  localparam logic [7:0] T_FIRST = 8'h0c;
  localparam logic [7:0] T_WRITE = 8'h1c;
  localparam logic [7:0] T_LAST  = 8'h2c;

  typedef struct packed {
    logic        v;
    logic [63:0] d;
  } blk_t;

  typedef struct packed {
    logic         req;
    logic [55:0]  hdr;
    logic [111:0] addr;
    logic         chunk;
    logic [63:0]  cd;
    logic         last;
    logic         err;
    logic [2:0]   code;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] rx_len = '0;
  logic [63:0] rx_data_a = '0, rx_data_b = '0;
  logic rx_valid_a = 1'b0, rx_valid_b = 1'b0;

  logic [55:0]  hdr_a, hdr_b;
  logic [111:0] addr_a, addr_b;
  logic [63:0]  cd_a, cd_b;
  logic         req_a, req_b, cv_a, cv_b, cl_a, cl_b, err_a, err_b;
  logic [2:0]   code_o_a, code_o_b;

  blk_t stim[$];
  exp_t expq[$];
  int   n_checks = 0, n_pass = 0, n_fail = 0;
  logic [2:0] code_a = '0, code_b = '0;

  always #5 clk = ~clk;

  ipg_wreq_rx dut_a (
    .clk(clk), .reset(reset), .rx_ipg_data(rx_data_a), .rx_len(rx_len), .rx_valid(rx_valid_a),
    .hdr_out(hdr_a), .addr_out(addr_a), .req_valid(req_a), .chunk_data(cd_a),
    .chunk_valid(cv_a), .chunk_last(cl_a), .err(err_a), .err_code(code_o_a)
  );

  ipg_wreq_rx #(.MAX_CHUNKS(4)) dut_b (
    .clk(clk), .reset(reset), .rx_ipg_data(rx_data_b), .rx_len(rx_len), .rx_valid(rx_valid_b),
    .hdr_out(hdr_b), .addr_out(addr_b), .req_valid(req_b), .chunk_data(cd_b),
    .chunk_valid(cv_b), .chunk_last(cl_b), .err(err_b), .err_code(code_o_b)
  );

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [55:0] rnd56();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[55:0];
  endfunction

  function automatic logic [7:0] foreign_t();
    logic [7:0] t;
    do t = 8'($urandom()); while (t == T_FIRST || t == T_WRITE || t == T_LAST);
    return t;
  endfunction

  task automatic push(input logic v, input logic [63:0] d, output int idx);
    blk_t b;
    exp_t e;
    b.v = v;
    b.d = d;
    e = '0;
    stim.push_back(b);
    expq.push_back(e);
    idx = stim.size() - 1;
  endtask

  task automatic gap(input int n);
    int t;
    for (int k = 0; k < n; k++) push(1'b0, {$urandom(), $urandom()}, t);
  endtask

  // One request: header, address blocks, ndata data beats (last one LAST if with_last).
  task automatic frame(input int len, input int ndata, input int mc, input int maxg, input bit with_last);
    logic [55:0]  h, a;
    logic [111:0] av;
    logic [63:0]  d;
    int idx, expb;
    bit drop, is_last;
    h = rnd56();
    h[15:0] = len[15:0];
    av = '0;
    push(1'b1, {h, T_FIRST}, idx);
    for (int k = 0; k < 2; k++) begin
      gap($urandom_range(maxg, 0));
      a = rnd56();
      av[(2-k)*56-1 -: 56] = a;
      push(1'b1, {a, T_WRITE}, idx);
    end
    expq[idx].req  = 1'b1;
    expq[idx].hdr  = h;
    expq[idx].addr = av;
    expb = (len == 0) ? 1 : (len + 6) / 7;
    drop = 1'b0;
    for (int b = 1; b <= ndata; b++) begin
      is_last = with_last && (b == ndata);
      gap($urandom_range(maxg, 0));
      d = {rnd56(), is_last ? T_LAST : T_WRITE};
      push(1'b1, d, idx);
      if (!drop) begin
        expq[idx].chunk = 1'b1;
        expq[idx].cd    = d;
        if (is_last) begin
          expq[idx].last = 1'b1;
          if (b != expb) begin
            expq[idx].err  = 1'b1;
            expq[idx].code = 3'd5;
          end
        end else if (b == mc) begin
          expq[idx].err  = 1'b1;
          expq[idx].code = 3'd4;
          drop = 1'b1;
        end
      end
    end
  endtask

  task automatic set_err(input int idx, input logic [2:0] c);
    expq[idx].err  = 1'b1;
    expq[idx].code = c;
  endtask

  task automatic check_slot(input int sel, input exp_t e, input int i);
    logic o_req, o_cv, o_cl, o_err;
    logic [2:0] o_code, want_code;
    logic [55:0] o_hdr;
    logic [111:0] o_addr;
    logic [63:0] o_cd;
    if (sel == 0) begin
      o_req = req_a; o_cv = cv_a; o_cl = cl_a; o_err = err_a;
      o_code = code_o_a; o_hdr = hdr_a; o_addr = addr_a; o_cd = cd_a;
      if (e.err) code_a = e.code;
      want_code = code_a;
    end else begin
      o_req = req_b; o_cv = cv_b; o_cl = cl_b; o_err = err_b;
      o_code = code_o_b; o_hdr = hdr_b; o_addr = addr_b; o_cd = cd_b;
      if (e.err) code_b = e.code;
      want_code = code_b;
    end
    chk($sformatf("req_valid dut%0d slot%0d", sel, i), 128'(o_req), 128'(e.req));
    chk($sformatf("chunk_valid dut%0d slot%0d", sel, i), 128'(o_cv), 128'(e.chunk));
    chk($sformatf("chunk_last dut%0d slot%0d", sel, i), 128'(o_cl), 128'(e.last));
    chk($sformatf("err dut%0d slot%0d", sel, i), 128'(o_err), 128'(e.err));
    chk($sformatf("err_code dut%0d slot%0d", sel, i), 128'(o_code), 128'(want_code));
    if (e.req) begin
      chk($sformatf("hdr_out dut%0d slot%0d", sel, i), 128'(o_hdr), 128'(e.hdr));
      chk($sformatf("addr_out dut%0d slot%0d", sel, i), 128'(o_addr), 128'(e.addr));
    end
    if (e.chunk) chk($sformatf("chunk_data dut%0d slot%0d", sel, i), 128'(o_cd), 128'(e.cd));
  endtask

  task automatic run(input int sel);
    for (int i = 0; i < stim.size(); i++) begin
      rx_len = 6'($urandom());
      if (sel == 0) begin
        rx_valid_a = stim[i].v;
        rx_data_a  = stim[i].d;
      end else begin
        rx_valid_b = stim[i].v;
        rx_data_b  = stim[i].d;
      end
      @(negedge clk);
      check_slot(sel, expq[i], i);
    end
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    stim.delete();
    expq.delete();
  endtask

  initial begin
    int idx, len, expb, nd, first_idx;

    repeat (2) @(negedge clk);
    chk("reset req_valid", 128'(req_a), 128'(0));
    chk("reset chunk_valid", 128'(cv_a), 128'(0));
    chk("reset err_code", 128'(code_o_a), 128'(0));
    chk("reset hdr_out", 128'(hdr_a), 128'(0));
    reset = 1'b0;

    // Nominal frame, then the same frame with three idle cycles between blocks.
    for (int g = 0; g < 2; g++) begin
      push(1'b1, 64'h0000000000000E0c, idx);
      gap(3 * g);
      push(1'b1, 64'h111111111111111c, idx);
      gap(3 * g);
      push(1'b1, 64'h222222222222221c, idx);
      expq[idx].req  = 1'b1;
      expq[idx].hdr  = 56'h0000000000000E;
      expq[idx].addr = {56'h11111111111111, 56'h22222222222222};
      gap(3 * g);
      push(1'b1, 64'hD0D0D0D0D0D0D01c, idx);
      expq[idx].chunk = 1'b1;
      expq[idx].cd    = 64'hD0D0D0D0D0D0D01c;
      gap(3 * g);
      push(1'b1, 64'hD1D1D1D1D1D1D12c, idx);
      expq[idx].chunk = 1'b1;
      expq[idx].cd    = 64'hD1D1D1D1D1D1D12c;
      expq[idx].last  = 1'b1;
      gap(2);
    end
    run(0);

    // Length mismatch, blocks ignored while idle, and abort in ADDR.
    frame(14, 3, 256, 0, 1);
    push(1'b1, {rnd56(), T_WRITE}, idx);
    push(1'b1, {rnd56(), T_LAST}, idx);
    push(1'b1, {rnd56(), foreign_t()}, idx);
    push(1'b1, {rnd56(), T_FIRST}, idx);
    push(1'b1, {rnd56(), T_WRITE}, idx);
    first_idx = stim.size();
    frame(7, 1, 256, 0, 1);
    set_err(first_idx, 3'd1);
    gap(1);
    run(0);

    // SHORT, BADTYPE in ADDR with drain recovery by FIRST, BADTYPE in DATA with drain left by LAST.
    push(1'b1, {rnd56(), T_FIRST}, idx);
    push(1'b1, {rnd56(), T_WRITE}, idx);
    push(1'b1, {rnd56(), T_LAST}, idx);
    set_err(idx, 3'd2);
    push(1'b1, {rnd56(), T_FIRST}, idx);
    push(1'b1, {rnd56(), foreign_t()}, idx);
    set_err(idx, 3'd3);
    push(1'b1, {rnd56(), T_WRITE}, idx);
    frame(20, 3, 256, 1, 1);
    frame(30, 2, 256, 0, 0);
    push(1'b1, {rnd56(), foreign_t()}, idx);
    set_err(idx, 3'd3);
    push(1'b1, {rnd56(), T_WRITE}, idx);
    push(1'b1, {rnd56(), T_LAST}, idx);
    push(1'b1, {rnd56(), T_WRITE}, idx);
    frame(0, 1, 256, 0, 1);
    // Abort from DATA: the aborted frame never shows chunk_last.
    frame(21, 2, 256, 0, 0);
    first_idx = stim.size();
    frame(8, 2, 256, 2, 1);
    set_err(first_idx, 3'd1);
    run(0);

    // Idle stretches of 63 survive, 64 times out.
    frame(14, 1, 256, 0, 0);
    gap(63);
    push(1'b1, 64'hABABABABABABAB1c, idx);
    expq[idx].chunk = 1'b1;
    expq[idx].cd    = 64'hABABABABABABAB1c;
    gap(64);
    set_err(stim.size() - 1, 3'd6);
    push(1'b1, {rnd56(), T_LAST}, idx);
    gap(1);
    run(0);

    // Randomized frames with random gaps and idle junk.
    for (int r = 0; r < 25; r++) begin
      len  = $urandom_range(60, 0);
      expb = (len == 0) ? 1 : (len + 6) / 7;
      nd   = expb + $urandom_range(2, 0) - 1;
      if (nd < 1) nd = 1;
      frame(len, nd, 256, 3, 1);
      for (int j = $urandom_range(2, 0); j > 0; j--) begin
        case ($urandom_range(2, 0))
          0:       push(1'b1, {rnd56(), T_WRITE}, idx);
          1:       push(1'b1, {rnd56(), T_LAST}, idx);
          default: push(1'b1, {rnd56(), foreign_t()}, idx);
        endcase
      end
      gap($urandom_range(2, 0));
    end
    run(0);

    // MAX_CHUNKS=4 instance: overflow, exactly-at-limit LAST, random frames.
    frame(28, 6, 4, 0, 1);
    frame(7, 1, 4, 0, 1);
    frame(28, 4, 4, 1, 1);
    for (int r = 0; r < 12; r++) begin
      len  = $urandom_range(35, 0);
      expb = (len == 0) ? 1 : (len + 6) / 7;
      nd   = expb + $urandom_range(2, 0) - 1;
      if (nd < 1) nd = 1;
      frame(len, nd, 4, 2, 1);
    end
    run(1);

    // Asynchronous reset in the middle of DATA.
    frame(14, 2, 256, 0, 0);
    run(0);
    #2 reset = 1'b1;
    #1;
    chk("async reset chunk_valid", 128'(cv_a), 128'(0));
    chk("async reset chunk_data", 128'(cd_a), 128'(0));
    chk("async reset req_valid", 128'(req_a), 128'(0));
    chk("async reset err", 128'(err_a), 128'(0));
    chk("async reset err_code", 128'(code_o_a), 128'(0));
    chk("async reset hdr_out", 128'(hdr_a), 128'(0));
    chk("async reset addr_out", 128'(addr_a), 128'(0));
    code_a = '0;
    code_b = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    frame(14, 2, 256, 1, 1);
    gap(1);
    run(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ipg_wreq_rx.md
Name: ipg_wreq_rx

Overview:
Parametrised successor to the IPG write-request receiver. Parses a write-request frame carried in IPG blocks: one WRITFIRST header, ADDR_BLKS address blocks, then data blocks ending in WRITLAST. Emits a registered request descriptor, a framed chunk stream for the RAM write path, and error reporting. Sits between the IPG RX block extractor and the FakeDRAM request/write logic.

Parameters:
DATA_WIDTH, 64, IPG block width; bits [7:0] are block type, [DATA_WIDTH-1:8] are the 56-bit field.
HDR_WIDTH, 16, payload-length field width, taken from header bits [8+HDR_WIDTH-1:8], in bytes.
ADDR_BLKS, 2, number of address blocks after the header (1..4).
MAX_CHUNKS, 256, maximum data beats per request, including WRITLAST.
TIMEOUT_CYCLES, 64, idle cycles allowed mid-frame; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rx_ipg_data  in  DATA_WIDTH  received IPG block
rx_len  in  6  valid bit count of the block; informational, not checked
rx_valid  in  1  rx_ipg_data valid this cycle
hdr_out  out  56  latched header field
addr_out  out  56*ADDR_BLKS  address fields; block k at [(ADDR_BLKS-k)*56-1 -: 56]
req_valid  out  1  one-cycle pulse: hdr_out/addr_out valid
chunk_data  out  DATA_WIDTH  data block as received, type byte included
chunk_valid  out  1  chunk_data valid
chunk_last  out  1  with chunk_valid: this is the WRITLAST block
err  out  1  one-cycle error pulse
err_code  out  3  1=ABORT, 2=SHORT, 3=BADTYPE, 4=OVERFLOW, 5=LEN, 6=TIMEOUT; held until next err

Behaviour:
- Block types: FIRST=8'h0c, WRITE=8'h1c, LAST=8'h2c. Any other type is foreign.
- Reset: state IDLE; all outputs and counters are 0. Reset mid-frame discards the frame and emits no err.
- All outputs are registered: a response appears 1 cycle after the accepted input block. req_valid, chunk_valid and err are pulses.
- Cycles with rx_valid=0 are ignored and do not abort the frame. They increment the idle counter only in ADDR and DATA.
- The idle counter clears on each rx_valid. When it reaches TIMEOUT_CYCLES: err (TIMEOUT), go to IDLE.
- IDLE: FIRST latches hdr and len, clears addr_cnt and beat_cnt, goes to ADDR. All other blocks are ignored silently.
- ADDR, on WRITE: store the field at addr[addr_cnt] and increment addr_cnt.
  - If addr_cnt was ADDR_BLKS-1: pulse req_valid next cycle and go to DATA.
- ADDR, on FIRST: err (ABORT), restart with the new header (stay in ADDR, addr_cnt=0).
- ADDR, on LAST: err (SHORT), go to IDLE.
- ADDR, on a foreign type: err (BADTYPE), go to DRAIN.
- DATA, on WRITE or LAST: chunk_valid=1, chunk_data=block, beat_cnt+1. LAST also sets chunk_last.
  - exp = max(1, ceil(len/7)).
  - On LAST, if beat_cnt+1 != exp: err (LEN) in the same cycle as chunk_last. Go to IDLE either way.
  - On WRITE with beat_cnt+1 == MAX_CHUNKS: still forward the chunk, err (OVERFLOW), go to DRAIN.
- DATA, on FIRST: err (ABORT), restart as for IDLE→ADDR. chunk_last is never emitted for the aborted frame.
- DATA, on a foreign type: err (BADTYPE), go to DRAIN.
- DRAIN: discard all blocks, no chunk output. LAST goes to IDLE. FIRST latches the header and goes to ADDR, with no extra err.
- Simultaneous events: the timeout cannot coincide with rx_valid. When an error and a chunk occur together (LEN, OVERFLOW), both outputs assert in the same cycle.
- beat_cnt width is clog2(MAX_CHUNKS+1). The ceil(len/7) computation is done at HDR_WIDTH+1 bits, with no wrap.

Test Plan:
- Nominal: FIRST 64'h0000000000000E0c (len=14), WRITE 64'h1111...1c, WRITE 64'h2222...1c, WRITE D0 ...1c, LAST D1 ...2c.
  - Expect req_valid with hdr_out=56'h0000000000000E and addr_out={56'h111111111111..., 56'h222222222222...}.
  - Expect 2 chunks, chunk_last on D1, err=0.
- Gapped input: same frame with rx_valid low for 3 cycles between each block → identical outputs, no timeout.
- Length mismatch: len=14 with 3 data beats → chunk_last and err with err_code=5 in the same cycle.
- Abort: FIRST, one addr WRITE, then FIRST (len=7), 2 addr, LAST → err code 1 once, then 1 req_valid for the second header, one chunk, no further err.
- Overflow/timeout: with MAX_CHUNKS=4, 5 WRITE data beats → 4 chunks, err code 4 on the 4th, 5th dropped, LAST returns to IDLE. Separately, stall 64 cycles in DATA → err code 6.
- Reset mid-DATA: assert reset asynchronously between clock edges → outputs 0 immediately. The next FIRST is parsed normally.
